// File: rtl/c2h_byp_pkg.sv
// Shared types and constants for the C2H descriptor-bypass feeder and its ring index logic.
package c2h_byp_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOAD = 1'b1
  } byp_st_e;

  // XDMA descriptor control bit positions
  localparam int CTL_STOP      = 0;
  localparam int CTL_COMPLETED = 1;
  localparam int CTL_EOP       = 4;

  // Ring indices carry one extra wrap bit above the slot number
  function automatic int ring_idx_w(input int nr_slots);
    return $clog2(nr_slots) + 1;
  endfunction

endpackage

// File: rtl/c2h_ring_idx.sv
// Wrap-bit producer index plus registered consumer index; full is combinational from the two
// registers, so a consumer update is visible one cycle after it is sampled.
module c2h_ring_idx
  import c2h_byp_pkg::*;
#(
  parameter  int NR_SLOTS = 16,
  localparam int W        = ring_idx_w(NR_SLOTS)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic [W-1:0] cons_idx,
  output logic [W-1:0] idx,
  output logic         full
);

  logic [W-1:0] idx_q, idx_d;
  logic [W-1:0] cons_q, cons_d;

  always_comb begin
    idx_d  = idx_q + W'(inc);
    cons_d = cons_idx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q  <= '0;
      cons_q <= '0;
    end else begin
      idx_q  <= idx_d;
      cons_q <= cons_d;
    end
  end

  assign idx  = idx_q;
  // Modular difference; the wrap bit separates "empty" from "full"
  assign full = (idx_q - cons_q) == W'(NR_SLOTS);

endmodule

// File: rtl/c2h_dsc_byp_ctrl.sv
// XDMA C2H descriptor-bypass feeder: one registered descriptor per ring slot, at most 1 per 2 clk.
// A raised load holds until dsc_byp_ready; issue stalls on ring full or MAX_OUT unretired descriptors.
module c2h_dsc_byp_ctrl
  import c2h_byp_pkg::*;
#(
  parameter logic [63:0] HOST_BASE  = 64'h1_0000_0000,
  parameter int          SLOT_BYTES = 4096,
  parameter int          NR_SLOTS   = 16,
  parameter int          IDX_W      = 4,
  parameter int          MAX_OUT    = 4,
  parameter logic [15:0] DSC_CTL    = 16'h0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [IDX_W:0]   host_cons_idx,
  input  logic             dsc_byp_ready,
  output logic             dsc_byp_load,
  output logic [63:0]      dsc_byp_dst_addr,
  output logic [63:0]      dsc_byp_src_addr,
  output logic [27:0]      dsc_byp_len,
  output logic [15:0]      dsc_byp_ctl,
  input  logic             mon_tvalid,
  input  logic             mon_tready,
  input  logic             mon_tlast,
  output logic [IDX_W:0]   prod_idx,
  output logic [IDX_W:0]   outstanding,
  output logic             ring_full,
  output logic             err_orphan_last
);

  localparam int             SLOT_SHIFT = $clog2(SLOT_BYTES);
  localparam logic [IDX_W:0] MAX_OUT_C  = (IDX_W+1)'(MAX_OUT);

  byp_st_e        state_q, state_d;
  logic [63:0]    dst_q, dst_d;
  logic [IDX_W:0] out_q, out_d;
  logic           orphan_q, orphan_d;
  logic           accept;
  logic           retire;

  assign accept = dsc_byp_load && dsc_byp_ready;
  assign retire = mon_tvalid && mon_tready && mon_tlast;

  c2h_ring_idx #(
    .NR_SLOTS (NR_SLOTS)
  ) u_ring (
    .clk      (clk),
    .rst      (rst),
    .inc      (accept),
    .cons_idx (host_cons_idx),
    .idx      (prod_idx),
    .full     (ring_full)
  );

  always_comb begin
    state_d = state_q;
    dst_d   = dst_q;
    case (state_q)
      IDLE: begin
        if (enable && !ring_full && (out_q < MAX_OUT_C)) begin
          state_d = LOAD;
          // Slot bits only: the wrap bit never reaches the address
          dst_d   = HOST_BASE + (64'(prod_idx[IDX_W-1:0]) << SLOT_SHIFT);
        end
      end
      LOAD: begin
        if (dsc_byp_ready) begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_comb begin
    out_d    = out_q;
    orphan_d = orphan_q;
    if (accept && !retire) begin
      out_d = out_q + 1'b1;
    end else if (retire && !accept && (out_q != '0)) begin
      out_d = out_q - 1'b1;
    end
    if (retire && (out_q == '0)) begin
      orphan_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      dst_q    <= HOST_BASE;
      out_q    <= '0;
      orphan_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      dst_q    <= dst_d;
      out_q    <= out_d;
      orphan_q <= orphan_d;
    end
  end

  assign dsc_byp_load     = (state_q == LOAD);
  assign dsc_byp_dst_addr = dst_q;
  assign dsc_byp_src_addr = 64'h0;
  assign dsc_byp_len      = 28'(SLOT_BYTES);
  assign dsc_byp_ctl      = DSC_CTL;
  assign outstanding      = out_q;
  assign err_orphan_last  = orphan_q;

endmodule

// File: tb/tb_c2h_dsc_byp_ctrl.sv
// Directed scenarios plus randomized traffic against a slot/credit-level reference model.
module tb_c2h_dsc_byp_ctrl;

  localparam logic [63:0] BASE = 64'h1_0000_0000;
  localparam int          SB   = 4096;
  localparam int          NS   = 16;
  localparam int          MO   = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [4:0]  host_cons_idx = '0;
  logic        dsc_byp_ready = 1'b0;
  logic        dsc_byp_load;
  logic [63:0] dsc_byp_dst_addr;
  logic [63:0] dsc_byp_src_addr;
  logic [27:0] dsc_byp_len;
  logic [15:0] dsc_byp_ctl;
  logic        mon_tvalid = 1'b0;
  logic        mon_tready = 1'b0;
  logic        mon_tlast = 1'b0;
  logic [4:0]  prod_idx;
  logic [4:0]  outstanding;
  logic        ring_full;
  logic        err_orphan_last;

  c2h_dsc_byp_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .enable           (enable),
    .host_cons_idx    (host_cons_idx),
    .dsc_byp_ready    (dsc_byp_ready),
    .dsc_byp_load     (dsc_byp_load),
    .dsc_byp_dst_addr (dsc_byp_dst_addr),
    .dsc_byp_src_addr (dsc_byp_src_addr),
    .dsc_byp_len      (dsc_byp_len),
    .dsc_byp_ctl      (dsc_byp_ctl),
    .mon_tvalid       (mon_tvalid),
    .mon_tready       (mon_tready),
    .mon_tlast        (mon_tlast),
    .prod_idx         (prod_idx),
    .outstanding      (outstanding),
    .ring_full        (ring_full),
    .err_orphan_last  (err_orphan_last)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: issued-descriptor count, host consumer view, credits in flight
  logic        m_load;
  logic [63:0] m_dst;
  int          m_issued;   // total accepted since reset
  logic [4:0]  m_cons;     // consumer index as seen by the block (one cycle late)
  int          m_out;
  logic        m_orphan;
  int          n_acc;      // scoreboard count of observed accepts since reset

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int occupancy();
    return (m_issued - int'(m_cons)) & 31;
  endfunction

  function automatic logic [63:0] slot_addr(input int n);
    return BASE + 64'((n % NS) * SB);
  endfunction

  task automatic model_reset();
    m_load = 1'b0; m_dst = BASE; m_issued = 0; m_cons = '0;
    m_out = 0; m_orphan = 1'b0; n_acc = 0;
  endtask

  task automatic check_outputs();
    chk("load", 64'(dsc_byp_load), 64'(m_load));
    chk("dst", dsc_byp_dst_addr, m_dst);
    chk("prod", 64'(prod_idx), 64'(m_issued & 31));
    chk("outst", 64'(outstanding), 64'(m_out));
    chk("full", 64'(ring_full), 64'(occupancy() == NS));
    chk("orphan", 64'(err_orphan_last), 64'(m_orphan));
  endtask

  // One clock: scoreboard the accept, advance the model on the edge, compare 1 time unit later
  task automatic step();
    logic acc, ret, was_full;
    acc = m_load && dsc_byp_ready;
    ret = mon_tvalid && mon_tready && mon_tlast;
    was_full = (occupancy() == NS);
    if (acc && !rst) begin
      chk("acc_dst", dsc_byp_dst_addr, slot_addr(n_acc));
      n_acc++;
    end
    @(posedge clk);
    #1;
    if (rst) begin
      model_reset();
    end else begin
      if (m_load) begin
        if (acc) begin
          m_load = 1'b0;
          m_issued++;
        end
      end else if (enable && !was_full && m_out < MO) begin
        m_load = 1'b1;
        m_dst  = slot_addr(m_issued);
      end
      if (ret && m_out == 0) m_orphan = 1'b1;
      if (acc && !ret) m_out++;
      else if (ret && !acc && m_out > 0) m_out--;
      m_cons = host_cons_idx;
    end
    check_outputs();
  endtask

  task automatic wait_load(input int budget);
    int k = 0;
    while (!m_load && k < budget) begin
      step();
      k++;
    end
    if (!m_load) chk("wait_load_timeout", 64'(0), 64'(1));
  endtask

  task automatic set_tlast(input logic v);
    mon_tvalid = v; mon_tready = v; mon_tlast = v;
  endtask

  initial begin
    logic [63:0] d0;
    int          p0;
    int          o0;
    model_reset();

    // Reset state
    #12;
    chk("rst_load", 64'(dsc_byp_load), 64'(0));
    chk("rst_dst", dsc_byp_dst_addr, BASE);
    chk("rst_src", dsc_byp_src_addr, 64'(0));
    chk("rst_len", 64'(dsc_byp_len), 64'(SB));
    chk("rst_ctl", 64'(dsc_byp_ctl), 64'(0));
    chk("rst_prod", 64'(prod_idx), 64'(0));
    chk("rst_outst", 64'(outstanding), 64'(0));
    chk("rst_orphan", 64'(err_orphan_last), 64'(0));
    @(negedge clk);
    rst = 1'b0;

    // Free-running issue stops at MAX_OUT
    enable = 1'b1; dsc_byp_ready = 1'b1;
    for (int i = 0; i < 16; i++) step();
    chk("s1_accepts", 64'(n_acc), 64'(4));
    chk("s1_outst", 64'(outstanding), 64'(4));

    // Four retires release four more descriptors
    for (int i = 0; i < 4; i++) begin
      set_tlast(1'b1);
      step();
    end
    set_tlast(1'b0);
    for (int i = 0; i < 12; i++) step();
    chk("s2_accepts", 64'(n_acc), 64'(8));
    chk("s2_outst", 64'(outstanding), 64'(4));

    // Drain, then issue with a tlast per accept until the ring fills
    enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_tlast(1'b1);
      step();
    end
    enable = 1'b1;
    for (int i = 0; i < 40; i++) begin
      set_tlast(m_load && dsc_byp_ready);
      step();
    end
    set_tlast(1'b0);
    chk("s3_full", 64'(ring_full), 64'(1));
    chk("s3_prod", 64'(prod_idx), 64'(16));
    host_cons_idx = 5'd5;
    step();
    chk("s3_delay_load", 64'(dsc_byp_load), 64'(0));
    step();
    chk("s3_reload", 64'(dsc_byp_load), 64'(1));
    chk("s3_wrap_dst", dsc_byp_dst_addr, BASE);
    set_tlast(1'b1);
    step();
    set_tlast(1'b0);
    chk("s3_prod_wrap", 64'(prod_idx), 64'h11);

    // Backpressure: load and address hold while enable toggles
    dsc_byp_ready = 1'b0;
    wait_load(10);
    d0 = dsc_byp_dst_addr;
    p0 = m_issued;
    for (int i = 0; i < 10; i++) begin
      enable = i[0];
      step();
      chk("s4_hold_load", 64'(dsc_byp_load), 64'(1));
      chk("s4_hold_dst", dsc_byp_dst_addr, d0);
    end
    enable = 1'b0; dsc_byp_ready = 1'b1;
    step();
    chk("s4_one_acc", 64'(prod_idx), 64'((p0 + 1) & 31));
    step();
    chk("s4_no_reload", 64'(dsc_byp_load), 64'(0));

    // Accept and retire together; then an orphan tlast
    enable = 1'b1; dsc_byp_ready = 1'b0;
    wait_load(10);
    o0 = m_out;
    dsc_byp_ready = 1'b1; set_tlast(1'b1);
    step();
    chk("s5_same_cycle", 64'(outstanding), 64'(o0));
    enable = 1'b0; set_tlast(1'b0);
    step();
    for (int i = 0; i < 20 && m_out > 0; i++) begin
      set_tlast(1'b1);
      step();
    end
    set_tlast(1'b1);
    step();
    set_tlast(1'b0);
    chk("s5_orphan", 64'(err_orphan_last), 64'(1));
    chk("s5_orphan_out", 64'(outstanding), 64'(0));

    // Randomized traffic with a well-behaved host consumer
    for (int i = 0; i < 400; i++) begin
      enable        = ($urandom_range(0, 3) != 0);
      dsc_byp_ready = $urandom_range(0, 1) == 1;
      mon_tvalid    = ($urandom_range(0, 2) == 0);
      mon_tready    = ($urandom_range(0, 3) != 0);
      mon_tlast     = $urandom_range(0, 1) == 1;
      if (i % 4 == 0) host_cons_idx = m_cons + 5'($urandom_range(0, occupancy()));
      step();
    end
    set_tlast(1'b0);

    // Asynchronous reset while a load is pending
    enable = 1'b1; dsc_byp_ready = 1'b0;
    wait_load(40);
    #2 rst = 1'b1;
    #1;
    chk("s6_rst_load", 64'(dsc_byp_load), 64'(0));
    chk("s6_rst_prod", 64'(prod_idx), 64'(0));
    chk("s6_rst_outst", 64'(outstanding), 64'(0));
    chk("s6_rst_dst", dsc_byp_dst_addr, BASE);
    model_reset();
    host_cons_idx = '0;
    step();
    rst = 1'b0; dsc_byp_ready = 1'b1;
    wait_load(10);
    chk("s6_first_dst", dsc_byp_dst_addr, BASE);
    step();
    chk("s6_first_acc", 64'(prod_idx), 64'(1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
